// File: rtl/io_uart_tx_if.sv
// Processor IO bus bundle for io_uart_tx.
// The bus has no valid/ready pair. While IO_memWr_i is high, the slave
// accepts exactly one write per rising clock edge, at IO_memAddr_i with
// IO_memWData_i. The master never waits. IO_memRData_o is combinational from
// IO_memAddr_i, so a read completes within the cycle that presents the address.
interface io_uart_tx_if;
  logic [31:0] IO_memAddr_i;
  logic [31:0] IO_memWData_i;
  logic        IO_memWr_i;
  logic [31:0] IO_memRData_o;

  modport master (
    output IO_memAddr_i,
    output IO_memWData_i,
    output IO_memWr_i,
    input  IO_memRData_o
  );

  modport slave (
    input  IO_memAddr_i,
    input  IO_memWData_i,
    input  IO_memWr_i,
    output IO_memRData_o
  );
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter with a byte FIFO.
//   offset 0x0 DATA   : a write pushes one byte into the FIFO; a read returns 0.
//   offset 0x4 STATUS : [0] full, [1] empty, [2] overflow (write 1 to clear),
//                       [3] busy, [8+FIFO_AW:8] count.
// Frame format is 8N1 by default. Defining UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
// dbg_state_o exposes the serializer FSM state so checkers can bind to it.
module io_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          CLK_DIV   = 868,
  parameter int          FIFO_AW   = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  io_uart_tx_if.slave  bus,
  output logic         uartTx_o,
  output logic         txIdle_o,
  output logic [2:0]   dbg_state_o
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_CNT = DEPTH[FIFO_AW:0];
  localparam int                 BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0]      BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Address decode
  logic hit;
  logic data_sel;
  logic status_sel;
  logic data_wr;
  logic status_wr;

  assign hit        = (bus.IO_memAddr_i[31:4] == BASE_ADDR[31:4]);
  assign data_sel   = hit && (bus.IO_memAddr_i[3:0] == 4'h0);
  assign status_sel = hit && (bus.IO_memAddr_i[3:0] == 4'h4);
  assign data_wr    = bus.IO_memWr_i && data_sel;
  assign status_wr  = bus.IO_memWr_i && status_sel;

  // Only the low byte and the overflow-clear bit of the write data matter.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^bus.IO_memWData_i[31:8];

  // FIFO storage and bookkeeping
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               fifo_full;
  logic               fifo_empty;
  logic [7:0]         head;
  logic               push;
  logic               pop;

  // Serializer state
  state_t             state;
  logic [BW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               tx_q;
`ifdef UART_TX_PARITY_EN
  logic               parity_q;
`endif

  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  // Full is judged on the registered count, so a pop in the same cycle does
  // not make room for a write that arrives while full.
  assign push = data_wr && !fifo_full;
  assign pop  = !fifo_empty &&
                ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == '0)));

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.IO_memWData_i[7:0];
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (data_wr && fifo_full) begin
        overflow <= 1'b1;
      end else if (status_wr && bus.IO_memWData_i[2]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Frame serializer: one bit every CLK_DIV cycles, line held in tx_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      tx_q     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shreg    <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            state    <= ST_START;
            tx_q     <= 1'b0;
            baud_cnt <= BAUD_LAST;
          end
        end

        ST_START: begin
          if (baud_cnt == '0) begin
            state    <= ST_DATA;
            tx_q     <= shreg[0];
            bit_idx  <= '0;
            baud_cnt <= BAUD_LAST;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx_q  <= parity_q;
`else
              state <= ST_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_cnt == '0) begin
            state    <= ST_STOP;
            tx_q     <= 1'b1;
            baud_cnt <= BAUD_LAST;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (baud_cnt == '0) begin
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) begin
              shreg    <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
              state    <= ST_START;
              tx_q     <= 1'b0;
              baud_cnt <= BAUD_LAST;
            end else begin
              state <= ST_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // Register read mux; DATA and undecoded addresses read as zero.
  always_comb begin
    bus.IO_memRData_o = '0;
    if (status_sel) begin
      bus.IO_memRData_o[0]             = fifo_full;
      bus.IO_memRData_o[1]             = fifo_empty;
      bus.IO_memRData_o[2]             = overflow;
      bus.IO_memRData_o[3]             = (state != ST_IDLE);
      bus.IO_memRData_o[8+FIFO_AW:8]   = count;
    end
  end

  assign uartTx_o    = tx_q;
  assign txIdle_o    = fifo_empty && (state == ST_IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: random bytes go through the register port. Each
// accepted byte is queued as expected. A serial-line monitor decodes every
// frame from uartTx_o and compares it against the head of that queue.
module tb_io_uart_tx;
  localparam int          CLK_DIV = 4;
  localparam int          FIFO_AW = 4;
  localparam logic [31:0] BASE    = 32'h0000_0100;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif
  localparam int          FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_tx;
  logic       tx_idle;
  logic [2:0] dbg_state;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (CLK_DIV),
    .FIFO_AW   (FIFO_AW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .bus         (bus),
    .uartTx_o    (uart_tx),
    .txIdle_o    (tx_idle),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  int          frames_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial-line monitor: detects a start bit and checks every sample of the frame.
  bit         mon_busy = 1'b0;
  logic       prev_line = 1'b1;
  int         mon_pos;
  int         mon_bad;
  int         bit_n;
  logic [7:0] mon_exp;
  logic [7:0] mon_got;
  logic       e_bit;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy  = 1'b0;
      prev_line = 1'b1;
    end else begin
      if (!mon_busy) begin
        if (prev_line && !uart_tx) begin
          mon_busy = 1'b1;
          mon_pos  = 0;
          mon_bad  = 0;
          mon_got  = 8'h00;
          frames_seen++;
          start_q.push_back(cyc);
          check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        end
      end else begin
        mon_pos++;
      end
      if (mon_busy) begin
        bit_n = mon_pos / CLK_DIV;
        if (bit_n == 0)                             e_bit = 1'b0;
        else if (bit_n <= 8)                        e_bit = mon_exp[bit_n-1];
        else if (FRAME_BITS == 11 && bit_n == 9)    e_bit = ^mon_exp;
        else                                        e_bit = 1'b1;
        if (uart_tx !== e_bit) mon_bad++;
        if (bit_n >= 1 && bit_n <= 8 && (mon_pos % CLK_DIV) == CLK_DIV / 2)
          mon_got[bit_n-1] = uart_tx;
        if (mon_pos == FRAME_CYC - 1) begin
          check("frame_bit_timing", mon_bad, 0);
          check("frame_byte", {24'd0, mon_got}, {24'd0, mon_exp});
          mon_busy = 1'b0;
        end
      end
      prev_line = uart_tx;
    end
  end

  // Driver tasks
  task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.IO_memAddr_i  = a;
    bus.IO_memWData_i = d;
    bus.IO_memWr_i    = 1'b1;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.IO_memWr_i   = 1'b0;
    bus.IO_memAddr_i = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.IO_memWr_i   = 1'b0;
    bus.IO_memAddr_i = a;
    #1;
    d = bus.IO_memRData_o;
  endtask

  task automatic wait_idle(input int budget, output int unsigned at);
    int n;
    n  = 0;
    at = 0;
    while (1) begin
      @(negedge clk);
      if (tx_idle) begin
        at = cyc;
        break;
      end
      n++;
      if (n > budget) begin
        check("idle_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] d;
    int unsigned t;
    int          n;
    int          fb;
    logic [7:0]  b;

    rst = 1'b1;
    bus.IO_memAddr_i  = 32'h0;
    bus.IO_memWData_i = 32'h0;
    bus.IO_memWr_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_line", {31'd0, uart_tx}, 32'd1);
    check("reset_tx_idle", {31'd0, tx_idle}, 32'd1);
    rst = 1'b0;
    rd(BASE + 32'h4, d);
    check("reset_status", d, 32'h0000_0002);
    rd(BASE, d);
    check("data_reads_zero", d, 32'h0);

    // Single 0x55 frame: start bit at k+1, idle 40 cycles after the fall
    start_q.delete();
    exp_q.push_back(8'h55);
    wr_cycle(BASE, 32'h55);
    bus_idle();
    check("line_high_at_write_edge", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    check("start_bit_next_edge", {31'd0, uart_tx}, 32'd0);
    wait_idle(200, t);
    if (start_q.size() == 0) check("frame_seen_0x55", 32'd0, 32'd1);
    else check("idle_after_frame", t - start_q[0], FRAME_CYC);

    // Random bursts that fit in the FIFO
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        wr_cycle(BASE, {24'($urandom), b});
      end
      bus_idle();
      wait_idle(n * FRAME_CYC + 100, t);
      check("burst_drained", exp_q.size(), 0);
    end

    // 18 back-to-back writes: one popped, 16 stored, last dropped
    start_q.delete();
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 17) exp_q.push_back(b);
      wr_cycle(BASE, {24'd0, b});
    end
    bus_idle();
    rd(BASE + 32'h4, d);
    check("status_full_overflow", d, 32'h0000_100D);
    wr_cycle(BASE + 32'h4, 32'h4);
    bus_idle();
    rd(BASE + 32'h4, d);
    check("status_overflow_cleared", d, 32'h0000_1009);
    wait_idle(17 * FRAME_CYC + 100, t);
    check("burst_frame_count", start_q.size(), 17);
    fb = start_q.size();
    for (int i = 1; i < fb; i++)
      check("back_to_back_gap", start_q[i] - start_q[i-1], FRAME_CYC);
    rd(BASE + 32'h4, d);
    check("status_after_burst", d, 32'h0000_0002);

    // Reset during data bit 3 of a frame with one more byte waiting
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A);
    wr_cycle(BASE, 32'h00);
    wr_cycle(BASE, 32'h5A);
    bus_idle();
    n = 0;
    while (uart_tx && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_frame_started", {31'd0, uart_tx}, 32'd0);
    repeat (17) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_line_high", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    rd(BASE + 32'h4, d);
    check("reset_mid_status", d, 32'h0000_0002);
    check("reset_mid_idle", {31'd0, tx_idle}, 32'd1);
    fb = frames_seen;
    repeat (100) @(negedge clk);
    check("no_frame_after_reset", frames_seen, fb);

    // Undecoded addresses: no frame, reads return zero
    fb = frames_seen;
    wr_cycle(BASE + 32'h10, 32'hAA);
    wr_cycle(BASE + 32'h8, 32'h55);
    bus_idle();
    rd(BASE + 32'h8, d);
    check("offset8_reads_zero", d, 32'h0);
    rd(BASE + 32'hC, d);
    check("offsetC_reads_zero", d, 32'h0);
    rd(BASE + 32'h14, d);
    check("miss_reads_zero", d, 32'h0);
    repeat (60) @(negedge clk);
    check("no_frame_from_miss", frames_seen, fb);
    rd(BASE + 32'h4, d);
    check("status_after_miss", d, 32'h0000_0002);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
